// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt/exception sequencer feeding the SPR file's jisr/eret/mca/rpt.
// Collects pipeline cause pulses and latched external lines, masks them with sr,
// issues a one-cycle jisr or eret pulse, then flushes for FLUSH_CYCLES cycles.
// The boot jisr (cause 0) is issued on the first edge after reset.
// Optional: define INTR_STATS_EN to add the intr_count / last_il statistics ports.
module intr_ctrl #(
  parameter int N_EXT        = 16,  // external lines occupy cause bits 7..22
  parameter int FLUSH_CYCLES = 2    // 1..15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic             ill,
  input  logic             mal,
  input  logic             pff,
  input  logic             pfls,
  input  logic             sysc,
  input  logic             ovf,
  input  logic [N_EXT-1:0] ext_irq,
  input  logic             eret_req,
  input  logic [31:0]      sr,
  output logic             jisr,
  output logic             eret,
  output logic [22:0]      mca,
  output logic             rpt,
  output logic [4:0]       il,
  output logic             flush,
  output logic             busy,
  output logic [N_EXT-1:0] ext_pend
`ifdef INTR_STATS_EN
  ,
  output logic [31:0]      intr_count,
  output logic [4:0]       last_il
`endif
);

  typedef enum logic [2:0] {BOOT, RUN, JISR, ERET, FLUSH} state_t;

  state_t           state, nxt;
  logic [3:0]       cnt, cnt_d;
  logic [22:0]      ca, mc;
  logic [4:0]       lo;
  logic [22:0]      mca_d;
  logic [4:0]       il_d;
  logic             rpt_d;
  logic [N_EXT-1:0] pend_d;

  // Cause vector, mask, and lowest-index priority pick (only meaningful in RUN)
  always_comb begin
    ca       = '0;
    ca[6:1]  = {ovf, sysc, pfls, pff, mal, ill} & {6{instr_valid}};
    ca[22:7] = ext_pend | ext_irq;
    mc       = {ca[22:6] & sr[22:6], ca[5:0]};
    lo       = 5'd0;
    for (int i = 22; i >= 0; i--)
      if (mc[i]) lo = 5'(i);
  end

  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    nxt    = state;
    cnt_d  = cnt;
    mca_d  = mca;
    il_d   = il;
    rpt_d  = rpt;
    pend_d = ext_pend | ext_irq;  // external lines are never lost outside RUN
    case (state)
      BOOT: begin
        nxt   = JISR;
        mca_d = 23'h000001;
        il_d  = 5'd0;
        rpt_d = 1'b0;
      end
      RUN: begin
        if (mc != '0) begin
          nxt    = JISR;
          mca_d  = mc;
          il_d   = lo;
          rpt_d  = (lo == 5'd3) || (lo == 5'd4);
          // taken external interrupts are consumed on the same edge
          pend_d = (ext_pend | ext_irq) & ~mc[22:7];
        end else if (eret_req && instr_valid) begin
          nxt   = ERET;
          mca_d = '0;
          rpt_d = 1'b0;
        end
      end
      JISR, ERET: begin
        nxt   = FLUSH;
        cnt_d = 4'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (cnt == 4'd0) nxt = RUN;
        else             cnt_d = cnt - 4'd1;
      end
      default: nxt = BOOT;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      cnt      <= '0;
      ext_pend <= '0;
      jisr     <= 1'b0;
      eret     <= 1'b0;
      flush    <= 1'b0;
      busy     <= 1'b1;
      mca      <= '0;
      il       <= '0;
      rpt      <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= cnt_d;
      ext_pend <= pend_d;
      jisr     <= (nxt == JISR);
      eret     <= (nxt == ERET);
      flush    <= (nxt == JISR) || (nxt == ERET) || (nxt == FLUSH);
      busy     <= (nxt != RUN);
      mca      <= mca_d;
      il       <= il_d;
      rpt      <= rpt_d;
    end
  end

`ifdef INTR_STATS_EN
  // Count jisr cycles (boot included) and remember the last taken index
  always_ff @(posedge clk) begin
    if (reset) begin
      intr_count <= '0;
      last_il    <= '0;
    end else if (jisr) begin
      intr_count <= intr_count + 32'd1;
      last_il    <= il;
    end
  end
`endif

endmodule
